// File: rtl/avg_window_alarm_pkg.sv
// Shared types and constants for the windowed-average alarm block.
package avg_alarm_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_WIN_LOG2 = 2;
    localparam int DEF_DEBOUNCE = 3;

    // A sum of 2^L samples of W bits needs W+L bits to be overflow-free.
    function automatic int sum_width(input int width, input int win_log2);
        return width + win_log2;
    endfunction

    localparam int DEF_SUM_WIDTH = sum_width(DEF_WIDTH, DEF_WIN_LOG2);

    typedef logic signed [DEF_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_NORM = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } state_e;

endpackage

// File: rtl/avg_window_alarm_if.sv
// Sample stream, thresholds and alarm outputs of the windowed-average alarm.
interface avg_window_alarm_if
    import avg_alarm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic                    valid;
    logic signed [WIDTH-1:0] data_in;
    logic signed [WIDTH-1:0] hi_th;
    logic signed [WIDTH-1:0] lo_th;
    logic                    clear;

    logic signed [WIDTH-1:0] win_avg;
    logic                    win_valid;
    logic                    alarm_hi;
    logic                    alarm_lo;
    state_e                  state;

    // Producer / supervisor side: drives samples and thresholds, observes alarms.
    modport master (
        output valid, data_in, hi_th, lo_th, clear,
        input  win_avg, win_valid, alarm_hi, alarm_lo, state
    );

    // Alarm block side.
    modport slave (
        input  valid, data_in, hi_th, lo_th, clear,
        output win_avg, win_valid, alarm_hi, alarm_lo, state
    );

endinterface

// File: rtl/avg_window_alarm_win_sum.sv
// Sliding window of the last 2^WIN_LOG2 accepted samples with a running sum.
// Presents the mean the window will hold after the current sample and a
// strobe that says this edge accepts a sample into a full window.
module win_sum
    import avg_alarm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data,
    output logic signed [WIDTH-1:0] o_mean_next,
    output logic                    o_full_update
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SUM_W = sum_width(WIDTH, WIN_LOG2);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic signed [WIDTH-1:0] r_win     [DEPTH];
    logic signed [WIDTH-1:0] w_tap_in  [DEPTH];
    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] w_sum_next;
    logic signed [SUM_W-1:0] w_data_ext;
    logic signed [SUM_W-1:0] w_oldest_ext;
    logic [CNT_W-1:0]        r_fill;
    logic [CNT_W-1:0]        w_fill_next;
    logic                    w_full_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign w_tap_in[gi] = i_data;
            end else begin : g_body
                assign w_tap_in[gi] = r_win[gi-1];
            end

            // Shift the window by one tap on every accepted sample.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_win[gi] <= '0;
                end else if (i_clear) begin
                    r_win[gi] <= '0;
                end else if (i_valid) begin
                    r_win[gi] <= w_tap_in[gi];
                end
            end
        end
    endgenerate

    // Signed assignments sign-extend into the wider sum domain.
    assign w_data_ext   = i_data;
    assign w_oldest_ext = r_win[DEPTH-1];
    assign w_sum_next   = r_sum + w_data_ext - w_oldest_ext;

    assign w_fill_next  = (r_fill == CNT_W'(DEPTH)) ? r_fill : r_fill + 1'b1;
    assign w_full_next  = (w_fill_next == CNT_W'(DEPTH));

    // Bits above the shift amount are the arithmetic shift (floor toward -inf);
    // the mean of WIDTH-bit samples always fits back into WIDTH bits.
    assign o_mean_next   = w_sum_next[WIN_LOG2 +: WIDTH];
    assign o_full_update = i_valid && !i_clear && w_full_next;

    // Running sum and saturating fill count, updated per accepted sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_valid) begin
            r_sum  <= w_sum_next;
            r_fill <= w_fill_next;
        end
    end

endmodule

// File: rtl/avg_window_alarm.sv
// Windowed mean of a signed sample stream with a debounced hysteresis FSM
// that raises high/low alarms. The FSM evaluates one edge after each mean
// update, using the registered mean.
module avg_window_alarm
    import avg_alarm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    avg_window_alarm_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic signed [WIDTH-1:0] w_mean_next;
    logic                    w_update;
    logic signed [WIDTH-1:0] r_win_avg;
    logic                    r_win_valid;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [CNT_W-1:0]        w_streak;
    logic                    r_last_above;
    logic                    w_last_above_next;
    logic                    w_above;
    logic                    w_below;

    win_sum #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) u_win_sum (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (bus.clear),
        .i_valid       (bus.valid),
        .i_data        (bus.data_in),
        .o_mean_next   (w_mean_next),
        .o_full_update (w_update)
    );

    // Mean register and its one-cycle update strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win_avg   <= '0;
            r_win_valid <= 1'b0;
        end else if (bus.clear) begin
            r_win_avg   <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= w_update;
            if (w_update) begin
                r_win_avg <= w_mean_next;
            end
        end
    end

    // High takes precedence when the thresholds are inverted.
    assign w_above   = (r_win_avg > bus.hi_th);
    assign w_below   = !w_above && (r_win_avg < bus.lo_th);
    assign w_cnt_inc = (r_cnt == CNT_W'(DEBOUNCE)) ? r_cnt : r_cnt + 1'b1;

    // FSM state, debounce count and direction of the last qualifying update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_FILL;
            r_cnt        <= '0;
            r_last_above <= 1'b0;
        end else if (bus.clear) begin
            r_state      <= ST_FILL;
            r_cnt        <= '0;
            r_last_above <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_last_above <= w_last_above_next;
        end
    end

    // Next-state and debounce logic; only mean updates move the FSM.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_last_above_next = r_last_above;
        w_streak          = '0;

        unique case (r_state)
            ST_FILL: begin
                if (w_update) begin
                    w_state_next = ST_NORM;
                    w_cnt_next   = '0;
                end
            end

            ST_NORM: begin
                if (r_win_valid) begin
                    if (w_above) begin
                        w_streak          = r_last_above ? w_cnt_inc : CNT_W'(1);
                        w_last_above_next = 1'b1;
                        if (w_streak == CNT_W'(DEBOUNCE)) begin
                            w_state_next = ST_HI;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next   = w_streak;
                        end
                    end else if (w_below) begin
                        w_streak          = r_last_above ? CNT_W'(1) : w_cnt_inc;
                        w_last_above_next = 1'b0;
                        if (w_streak == CNT_W'(DEBOUNCE)) begin
                            w_state_next = ST_LO;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next   = w_streak;
                        end
                    end else begin
                        w_cnt_next = '0;
                    end
                end
            end

            ST_HI: begin
                if (r_win_valid) begin
                    if (w_above) begin
                        w_cnt_next = '0;
                    end else if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                        w_state_next = ST_NORM;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
            end

            ST_LO: begin
                if (r_win_valid) begin
                    if (w_below) begin
                        w_cnt_next = '0;
                    end else if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                        w_state_next = ST_NORM;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_state_next = ST_FILL;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.win_avg   = r_win_avg;
    assign bus.win_valid = r_win_valid;
    assign bus.state     = r_state;
    assign bus.alarm_hi  = (r_state == ST_HI);
    assign bus.alarm_lo  = (r_state == ST_LO);

endmodule

// File: tb/tb_avg_window_alarm.sv
// Randomised and directed bench for avg_window_alarm against a queue-based
// reference model of the windowed mean and the debounced alarm rules.
module tb_avg_window_alarm;
    import avg_alarm_pkg::*;

    localparam int WIDTH    = 8;
    localparam int WIN_LOG2 = 2;
    localparam int DEBOUNCE = 3;
    localparam int DEPTH    = 1 << WIN_LOG2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avg_window_alarm_if #(.WIDTH(WIDTH)) bus ();

    avg_window_alarm #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int q_win[$];
    int m_avg       = 0;
    bit m_wv        = 0;
    int m_state     = 0;   // 0 fill, 1 norm, 2 high alarm, 3 low alarm
    int m_cnt       = 0;
    bit m_last_up   = 0;   // last qualifying update was "above"

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        q_win.delete();
        m_avg = 0; m_wv = 0; m_state = 0; m_cnt = 0; m_last_up = 0;
    endtask

    task automatic model_step();
        int  st, cnt, s;
        bit  lu, above, below, new_wv;
        if (bus.clear) begin
            model_reset();
            return;
        end
        st = m_state; cnt = m_cnt; lu = m_last_up;
        if (m_wv) begin
            above = (m_avg > int'(bus.hi_th));
            below = !above && (m_avg < int'(bus.lo_th));
            if (st == 1) begin
                if (above) begin
                    cnt = (cnt > 0 && !lu) ? 1 : cnt + 1;
                    lu = 1;
                    if (cnt >= DEBOUNCE) begin st = 2; cnt = 0; end
                end else if (below) begin
                    cnt = (cnt > 0 && lu) ? 1 : cnt + 1;
                    lu = 0;
                    if (cnt >= DEBOUNCE) begin st = 3; cnt = 0; end
                end else begin
                    cnt = 0;
                end
            end else if (st == 2) begin
                cnt = above ? 0 : cnt + 1;
                if (cnt >= DEBOUNCE) begin st = 1; cnt = 0; end
            end else if (st == 3) begin
                cnt = below ? 0 : cnt + 1;
                if (cnt >= DEBOUNCE) begin st = 1; cnt = 0; end
            end
        end
        new_wv = 0;
        if (bus.valid) begin
            q_win.push_back(int'(bus.data_in));
            if (q_win.size() > DEPTH) void'(q_win.pop_front());
            if (q_win.size() == DEPTH) begin
                s = 0;
                foreach (q_win[k]) s += q_win[k];
                m_avg  = floor_div(s, DEPTH);
                new_wv = 1;
                if (st == 0) begin st = 1; cnt = 0; end
            end
        end
        m_wv = new_wv; m_state = st; m_cnt = cnt; m_last_up = lu;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every cycle: DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_win_avg",   int'(bus.win_avg),   m_avg);
        chk("model_win_valid", int'(bus.win_valid), int'(m_wv));
        chk("model_state",     int'(bus.state),     m_state);
        chk("model_alarm_hi",  int'(bus.alarm_hi),  int'(m_state == 2));
        chk("model_alarm_lo",  int'(bus.alarm_lo),  int'(m_state == 3));
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic push(input int d, input int gap);
        bus.valid   = 1'b1;
        bus.data_in = 8'(d);
        @(negedge clk);
        bus.valid   = 1'b0;
        $display("push d=%0d avg=%0d wv=%0d state=%0d hi=%0d lo=%0d",
                 d, int'(bus.win_avg), bus.win_valid, int'(bus.state), bus.alarm_hi, bus.alarm_lo);
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_pulse(input bit with_valid, input int d);
        bus.clear   = 1'b1;
        bus.valid   = with_valid;
        bus.data_in = 8'(d);
        @(negedge clk);
        bus.clear   = 1'b0;
        bus.valid   = 1'b0;
        $display("clear valid=%0d d=%0d state=%0d avg=%0d", with_valid, d, int'(bus.state), int'(bus.win_avg));
    endtask

    int bias;
    int d;

    initial begin
        model_reset();
        bus.valid = 0; bus.clear = 0; bus.data_in = '0;
        bus.hi_th = 8'sd50; bus.lo_th = -8'sd50;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_avg",   int'(bus.win_avg), 0);

        // 1: first fill
        push(10, 0); push(20, 0); push(30, 0);
        chk("fill_no_valid", int'(bus.win_valid), 0);
        chk("fill_state",    int'(bus.state), 0);
        push(40, 0);
        chk("fill_avg25",    int'(bus.win_avg), 25);
        chk("fill_valid",    int'(bus.win_valid), 1);
        chk("fill_to_norm",  int'(bus.state), 1);

        // 2: floor rounding and extremes
        push(-1, 0); push(-2, 0); push(-2, 0); push(-2, 0);
        chk("floor_neg7", int'(bus.win_avg), -2);
        repeat (4) push(-128, 0);
        chk("min_avg", int'(bus.win_avg), -128);
        repeat (4) push(127, 0);
        chk("max_avg", int'(bus.win_avg), 127);

        // 3: high alarm entry/exit, back-to-back
        clear_pulse(0, 0);
        repeat (5) push(100, 0);
        chk("hi_not_yet5", int'(bus.alarm_hi), 0);
        push(100, 0);
        chk("hi_not_yet6", int'(bus.alarm_hi), 0);
        @(negedge clk);
        chk("hi_entered", int'(bus.alarm_hi), 1);
        repeat (4) push(0, 0);
        chk("hi_still", int'(bus.alarm_hi), 1);
        @(negedge clk);
        chk("hi_exited", int'(bus.alarm_hi), 0);
        chk("lo_never",  int'(bus.alarm_lo), 0);

        // 4: same ramp with idle gaps
        clear_pulse(0, 0);
        repeat (5) push(100, 5);
        chk("gap_hi_not_yet", int'(bus.alarm_hi), 0);
        push(100, 5);
        chk("gap_hi_entered", int'(bus.alarm_hi), 1);
        repeat (3) push(0, 5);
        chk("gap_hi_still", int'(bus.alarm_hi), 1);
        push(0, 5);
        chk("gap_hi_exited", int'(bus.alarm_hi), 0);

        // 5: clear in HI with a simultaneous sample
        repeat (6) push(100, 0);
        @(negedge clk);
        chk("pre_clear_hi", int'(bus.state), 2);
        clear_pulse(1, 99);
        chk("clr_state", int'(bus.state), 0);
        chk("clr_alarm", int'(bus.alarm_hi), 0);
        chk("clr_avg",   int'(bus.win_avg), 0);
        repeat (3) push(8, 0);
        chk("clr_99_dropped", int'(bus.win_valid), 0);
        push(8, 0);
        chk("clr_refill_avg8", int'(bus.win_avg), 8);

        // 6: asynchronous reset while in LO with count 2
        repeat (8) push(-100, 0);
        repeat (3) push(0, 0);
        @(negedge clk);
        chk("lo_before_rst", int'(bus.alarm_lo), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_alarm", int'(bus.alarm_lo), 0);
        chk("arst_avg",   int'(bus.win_avg), 0);
        chk("arst_wv",    int'(bus.win_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(10, 0); push(20, 0); push(30, 0); push(40, 0);
        chk("rst_refill_avg25", int'(bus.win_avg), 25);
        chk("rst_refill_norm",  int'(bus.state), 1);

        // Random phase: drifting bias, random gaps, thresholds and clears.
        bias = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0: bias = 90;
                    1: bias = -90;
                    default: bias = 0;
                endcase
            end
            if (i % 150 == 0) begin
                bus.hi_th = 8'($urandom_range(0, 80) - 20);
                bus.lo_th = 8'($urandom_range(0, 80) - 60);
            end
            d = bias + int'($urandom_range(0, 60)) - 30;
            if (d > 127)  d = 127;
            if (d < -128) d = -128;
            bus.data_in = 8'(d);
            bus.valid   = ($urandom_range(0, 2) != 0);
            bus.clear   = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            if (bus.valid || bus.clear)
                $display("rand i=%0d d=%0d v=%0d clr=%0d avg=%0d state=%0d",
                         i, d, bus.valid, bus.clear, int'(bus.win_avg), int'(bus.state));
            bus.valid = 1'b0;
            bus.clear = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
